// File: rtl/at_cmd_pkg.sv
// rtl/at_cmd_pkg.sv - shared states, byte constants and command table for the AT command sender
package at_cmd_pkg;

  localparam int MAX_LEN_DEF = 32;
  localparam int CMD_W_DEF   = 3;
  localparam int N_TBL       = 4;
  localparam int STR_MAX     = 11;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEND  = 3'd2,
    S_WAITB = 3'd3,
    S_WAITD = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Slots 4 and up are empty and never reach this table.
  localparam int LEN [N_TBL] = '{2, 6, 11, 11};

  localparam logic [7:0] ROM [N_TBL][STR_MAX] = '{
    '{"A", "T", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{"A", "T", "+", "R", "S", "T", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{"A", "T", "+", "C", "W", "M", "O", "D", "E", "=", "1"},
    '{"A", "T", "+", "C", "I", "P", "M", "U", "X", "=", "0"}
  };

endpackage

// File: rtl/at_cmd_rom.sv
// rtl/at_cmd_rom.sv - combinational command byte/length lookup; AT_CRLF_EN appends CR LF to non-empty commands
module at_cmd_rom
  import at_cmd_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CMD_W   = CMD_W_DEF,
  parameter int IDX_W   = $clog2(MAX_LEN + 2)
) (
  input  logic [CMD_W-1:0] i_cmd,
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_byte,
  output logic [IDX_W-1:0] o_len
);

  int w_base;
  int w_eff;
  int w_i;

  always_comb begin
    w_base = 0;
    w_i    = int'(i_idx);
    o_byte = 8'h00;
    if ((i_cmd >> 2) == '0) w_base = LEN[i_cmd[1:0]];
`ifdef AT_CRLF_EN
    w_eff = (w_base == 0) ? 0 : w_base + 2;
`else
    w_eff = w_base;
`endif
    if (w_eff > MAX_LEN) w_eff = MAX_LEN;
    o_len = IDX_W'(w_eff);
    if (w_i < w_base) begin
      o_byte = ROM[i_cmd[1:0]][i_idx[3:0]];
    end
`ifdef AT_CRLF_EN
    else if (w_base != 0 && w_i == w_base) begin
      o_byte = CR;
    end else if (w_base != 0 && w_i == w_base + 1) begin
      o_byte = LF;
    end
`endif
  end

endmodule

// File: rtl/at_command_sender.sv
// rtl/at_command_sender.sv - streams the selected AT command string byte by byte into uart_tx (AT_CRLF_EN adds CR LF)
module at_command_sender
  import at_cmd_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CMD_W   = CMD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] command_1,
  input  logic             start,
  output logic             ready_command,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy
);

  localparam int IDX_W = $clog2(MAX_LEN + 2);

  state_t           r_state, w_next;
  logic [CMD_W-1:0] r_cmd, r_last, w_rom_cmd;
  logic             r_last_vld, r_ready, r_abort, w_launch;
  logic [IDX_W-1:0] r_idx, r_len, w_rom_len;
  logic [7:0]       r_tx_data, w_rom_byte;

  // Idle looks up the incoming index so len is ready at launch.
  assign w_rom_cmd = (r_state == S_IDLE) ? command_1 : r_cmd;

  at_cmd_rom #(.MAX_LEN(MAX_LEN), .CMD_W(CMD_W), .IDX_W(IDX_W)) u_rom (
    .i_cmd  (w_rom_cmd),
    .i_idx  (r_idx),
    .o_byte (w_rom_byte),
    .o_len  (w_rom_len)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    unique case (r_state)
      S_IDLE: if (start && (!r_last_vld || command_1 != r_last)) begin
        w_launch = 1'b1;
        w_next   = S_LOAD;
      end
      S_LOAD:  w_next = (r_idx == r_len) ? S_DONE : S_SEND;
      S_SEND:  w_next = S_WAITB;
      S_WAITB: if (tx_busy) w_next = S_WAITD;
      S_WAITD: if (!tx_busy) w_next = (r_abort || !start) ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_idx      <= '0;
      r_len      <= '0;
      r_ready    <= 1'b1;
      r_tx_data  <= 8'h00;
      r_abort    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && !start) r_last_vld <= 1'b0;
      if (w_launch) begin
        r_cmd      <= command_1;
        r_last     <= command_1;
        r_last_vld <= 1'b1;
        r_idx      <= '0;
        r_len      <= w_rom_len;
        r_ready    <= 1'b0;
        r_abort    <= 1'b0;
      end
      if (r_state == S_LOAD && r_idx != r_len) r_tx_data <= w_rom_byte;
      // A start drop mid-byte is remembered so a brief re-raise cannot resume the string.
      if ((r_state == S_WAITB || r_state == S_WAITD) && !start) r_abort <= 1'b1;
      if (r_state == S_WAITD && !tx_busy) r_idx <= r_idx + IDX_W'(1);
      if (r_state == S_DONE) r_ready <= 1'b1;
    end
  end

  assign ready_command = r_ready;
  assign tx_data       = r_tx_data;
  assign tx_start      = (r_state == S_SEND);

endmodule
